agc_ctrl: RTL and testbench

Acquisition/tracking sequencer for the AGC datapath. It starts power estimation and walks the loop through fast acquisition, slow acquisition and tracking, driven by the estimator's end-of-period pulse and the PWM generator's fix flag. It freezes the loop during non-service slots and flags a failed acquisition after a timeout. It sits between the receiver control registers and the AGC top level, driving that block's `agc_en`, `pwr_est_prd` and `pwm_ena`.

---
 rtl/agc_pkg.sv | 30 +++
 rtl/agc_run_cnt.sv | 43 ++++
 rtl/agc_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_agc_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/agc_pkg.sv
// Shared constants for the AGC acquisition/tracking sequencer.
package agc_pkg;

   localparam int unsigned ST_W  = 3;
   localparam int unsigned PRD_W = 2;

   // State codes, also driven out on agc_state
   localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
   localparam logic [ST_W-1:0] ST_FAST   = 3'd1;
   localparam logic [ST_W-1:0] ST_SLOW   = 3'd2;
   localparam logic [ST_W-1:0] ST_TRACK  = 3'd3;
   localparam logic [ST_W-1:0] ST_FROZEN = 3'd4;
   localparam logic [ST_W-1:0] ST_FAIL   = 3'd5;

   // Period code held on pwr_est_prd while in reset
   localparam logic [PRD_W-1:0] PRD_RST = 2'd0;

   // Estimation period code selected by a (non-frozen) state
   function automatic logic [PRD_W-1:0] prd_sel(input logic [ST_W-1:0]  st,
                                                 input logic [PRD_W-1:0] fast_prd,
                                                 input logic [PRD_W-1:0] slow_prd);
      logic [PRD_W-1:0] prd;
      prd = fast_prd;
      if (st == ST_SLOW || st == ST_TRACK) begin
         prd = slow_prd;
      end
      return prd;
   endfunction

endpackage

// File: rtl/agc_run_cnt.sv
// Saturating consecutive-event counter with a threshold-hit look-ahead.
module agc_run_cnt #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   input  logic [W-1:0] thresh,
   output logic         hit_c
);

   localparam logic [W-1:0] CNT_ONE = W'(1);
   localparam logic [W-1:0] CNT_MAX = '1;

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;
   logic [W-1:0] cnt_inc;
   logic [W-1:0] thr_eff;

   // hit_c reports whether an increment this cycle would reach the threshold
   always_comb begin
      cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      thr_eff = (thresh == '0) ? CNT_ONE : thresh;
      hit_c   = (cnt_inc >= thr_eff);
      cnt_d   = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_inc;
      end
   end

   // Counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/agc_ctrl.sv
// AGC acquisition/tracking sequencer: FAST -> SLOW -> TRACK with freeze and timeout.
module agc_ctrl
   import agc_pkg::*;
#(
   parameter int unsigned CNT_WID = 4,
   parameter int unsigned TO_WID  = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               acq_start,
   input  logic               acq_stop,
   input  logic               freeze,
   input  logic               pwr_est_end,
   input  logic               agc_fix,
   input  logic [1:0]         cfg_fast_prd,
   input  logic [1:0]         cfg_slow_prd,
   input  logic [CNT_WID-1:0] cfg_lock_cnt,
   input  logic [CNT_WID-1:0] cfg_unlock_cnt,
   input  logic [TO_WID-1:0]  cfg_timeout,
   output logic               agc_en,
   output logic [1:0]         pwr_est_prd,
   output logic               pwm_ena,
   output logic               agc_locked,
   output logic               agc_fail,
   output logic [2:0]         agc_state
);

   localparam logic [TO_WID-1:0] TO_MAX = '1;

   logic [ST_W-1:0]   state_q, state_d;
   logic [ST_W-1:0]   ret_q, ret_d;
   logic [TO_WID-1:0] to_cnt_q, to_cnt_d, to_cnt_inc;
   logic              agc_en_q, agc_en_d;
   logic              pwm_ena_q, pwm_ena_d;
   logic [PRD_W-1:0]  prd_q, prd_d;
   logic              locked_q, locked_d;
   logic              fail_q, fail_d;

   logic              fix_inc, fix_clr, fix_hit_c;
   logic              miss_inc, miss_clr, miss_hit_c;
   logic              start_ok;
   logic              advance;
   logic [ST_W-1:0]   prd_st;

   // Consecutive fix periods (FAST/SLOW lock)
   agc_run_cnt #(.W(CNT_WID)) u_fix_cnt (
      .clk    (clk),
      .reset  (reset),
      .inc    (fix_inc),
      .clr    (fix_clr),
      .thresh (cfg_lock_cnt),
      .hit_c  (fix_hit_c)
   );

   // Consecutive non-fix periods (TRACK unlock)
   agc_run_cnt #(.W(CNT_WID)) u_miss_cnt (
      .clk    (clk),
      .reset  (reset),
      .inc    (miss_inc),
      .clr    (miss_clr),
      .thresh (cfg_unlock_cnt),
      .hit_c  (miss_hit_c)
   );

   // Next state, counter control and Moore output decode of the next state
   always_comb begin
      state_d    = state_q;
      ret_d      = ret_q;
      to_cnt_d   = to_cnt_q;
      fix_inc    = 1'b0;
      fix_clr    = 1'b0;
      miss_inc   = 1'b0;
      miss_clr   = 1'b0;
      advance    = 1'b0;
      to_cnt_inc = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + TO_WID'(1);
      start_ok   = acq_start && (state_q == ST_IDLE || state_q == ST_FAIL);

      if (acq_stop || start_ok) begin
         state_d  = acq_stop ? ST_IDLE : ST_FAST;
         fix_clr  = 1'b1;
         miss_clr = 1'b1;
         to_cnt_d = '0;
      end else begin
         case (state_q)
            ST_FAST, ST_SLOW: begin
               if (freeze) begin
                  ret_d   = state_q;
                  state_d = ST_FROZEN;
               end else if (pwr_est_end) begin
                  to_cnt_d = to_cnt_inc;
                  if (agc_fix) begin
                     fix_inc = 1'b1;
                     if (fix_hit_c) begin
                        advance = 1'b1;
                        fix_clr = 1'b1;
                        if (state_q == ST_FAST) begin
                           state_d = ST_SLOW;
                        end else begin
                           state_d  = ST_TRACK;
                           to_cnt_d = '0;
                        end
                     end
                  end else begin
                     fix_clr = 1'b1;
                  end
                  // Advancing on the same pulse takes precedence over timeout
                  if (!advance && cfg_timeout != '0 && to_cnt_inc >= cfg_timeout) begin
                     state_d = ST_FAIL;
                  end
               end
            end
            ST_TRACK: begin
               if (freeze) begin
                  ret_d   = ST_TRACK;
                  state_d = ST_FROZEN;
               end else if (pwr_est_end) begin
                  if (!agc_fix) begin
                     miss_inc = 1'b1;
                     if (miss_hit_c) begin
                        miss_clr = 1'b1;
                        state_d  = ST_SLOW;
                     end
                  end else begin
                     miss_clr = 1'b1;
                  end
               end
            end
            ST_FROZEN: begin
               if (!freeze) begin
                  state_d  = ret_q;
                  fix_clr  = 1'b1;
                  miss_clr = 1'b1;
               end
            end
            ST_IDLE, ST_FAIL: begin
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      prd_st    = (state_d == ST_FROZEN) ? ret_d : state_d;
      agc_en_d  = (state_d == ST_FAST) || (state_d == ST_SLOW) || (state_d == ST_TRACK);
      pwm_ena_d = agc_en_d;
      prd_d     = prd_sel(prd_st, cfg_fast_prd, cfg_slow_prd);
      locked_d  = (state_d == ST_TRACK) || (state_d == ST_FROZEN && ret_d == ST_TRACK);
      fail_d    = (state_d == ST_FAIL);
   end

   // State, timeout counter and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         ret_q     <= ST_IDLE;
         to_cnt_q  <= '0;
         agc_en_q  <= 1'b0;
         pwm_ena_q <= 1'b0;
         prd_q     <= PRD_RST;
         locked_q  <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ret_q     <= ret_d;
         to_cnt_q  <= to_cnt_d;
         agc_en_q  <= agc_en_d;
         pwm_ena_q <= pwm_ena_d;
         prd_q     <= prd_d;
         locked_q  <= locked_d;
         fail_q    <= fail_d;
      end
   end

   assign agc_en      = agc_en_q;
   assign pwm_ena     = pwm_ena_q;
   assign pwr_est_prd = prd_q;
   assign agc_locked  = locked_q;
   assign agc_fail    = fail_q;
   assign agc_state   = state_q;

endmodule

// File: tb/tb_agc_ctrl.sv
// Self-checking bench for agc_ctrl: directed scenarios plus random traffic vs. a reference model.
module tb_agc_ctrl;

   localparam int CNT_WID = 4;
   localparam int TO_WID  = 8;

   logic               clk = 1'b0;
   logic               reset;
   logic               acq_start, acq_stop, freeze, pwr_est_end, agc_fix;
   logic [1:0]         cfg_fast_prd, cfg_slow_prd;
   logic [CNT_WID-1:0] cfg_lock_cnt, cfg_unlock_cnt;
   logic [TO_WID-1:0]  cfg_timeout;
   logic               agc_en, pwm_ena, agc_locked, agc_fail;
   logic [1:0]         pwr_est_prd;
   logic [2:0]         agc_state;

   agc_ctrl #(.CNT_WID(CNT_WID), .TO_WID(TO_WID)) dut (
      .clk            (clk),
      .reset          (reset),
      .acq_start      (acq_start),
      .acq_stop       (acq_stop),
      .freeze         (freeze),
      .pwr_est_end    (pwr_est_end),
      .agc_fix        (agc_fix),
      .cfg_fast_prd   (cfg_fast_prd),
      .cfg_slow_prd   (cfg_slow_prd),
      .cfg_lock_cnt   (cfg_lock_cnt),
      .cfg_unlock_cnt (cfg_unlock_cnt),
      .cfg_timeout    (cfg_timeout),
      .agc_en         (agc_en),
      .pwr_est_prd    (pwr_est_prd),
      .pwm_ena        (pwm_ena),
      .agc_locked     (agc_locked),
      .agc_fail       (agc_fail),
      .agc_state      (agc_state)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Single comparison point
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference model: state names IDLE=0 FAST=1 SLOW=2 TRACK=3 FROZEN=4 FAIL=5
   int m_st, m_ret, m_fix, m_miss, m_to;
   bit m_fail;

   function automatic int eff(input int c);
      return (c == 0) ? 1 : c;
   endfunction

   task automatic model_reset();
      m_st = 0; m_ret = 0; m_fix = 0; m_miss = 0; m_to = 0; m_fail = 0;
   endtask

   task automatic model_step();
      int  lock_n, unlock_n, tmo;
      bit  adv;
      lock_n   = eff(int'(cfg_lock_cnt));
      unlock_n = eff(int'(cfg_unlock_cnt));
      tmo      = int'(cfg_timeout);
      if (acq_stop) begin
         m_st = 0; m_fix = 0; m_miss = 0; m_to = 0; m_fail = 0;
      end else if (acq_start && (m_st == 0 || m_st == 5)) begin
         m_st = 1; m_fix = 0; m_miss = 0; m_to = 0; m_fail = 0;
      end else if (freeze && m_st >= 1 && m_st <= 3) begin
         m_ret = m_st;
         m_st  = 4;
      end else if (m_st == 4) begin
         if (!freeze) begin
            m_st = m_ret; m_fix = 0; m_miss = 0;
         end
      end else if (pwr_est_end && (m_st == 1 || m_st == 2)) begin
         m_to = (m_to < 255) ? m_to + 1 : 255;
         adv  = 0;
         if (agc_fix) begin
            m_fix = (m_fix < 15) ? m_fix + 1 : 15;
            if (m_fix >= lock_n) begin
               adv   = 1;
               m_fix = 0;
               if (m_st == 1) m_st = 2;
               else begin
                  m_st = 3;
                  m_to = 0;
               end
            end
         end else begin
            m_fix = 0;
         end
         if (!adv && tmo != 0 && m_to >= tmo) begin
            m_st   = 5;
            m_fail = 1;
         end
      end else if (pwr_est_end && m_st == 3) begin
         if (!agc_fix) begin
            m_miss = (m_miss < 15) ? m_miss + 1 : 15;
            if (m_miss >= unlock_n) begin
               m_st   = 2;
               m_miss = 0;
            end
         end else begin
            m_miss = 0;
         end
      end
   endtask

   task automatic check_outputs();
      int eff_st;
      bit run;
      run    = (m_st >= 1 && m_st <= 3);
      eff_st = (m_st == 4) ? m_ret : m_st;
      chk("agc_state", 32'(agc_state), 32'(m_st));
      chk("agc_en", 32'(agc_en), 32'(run));
      chk("pwm_ena", 32'(pwm_ena), 32'(run));
      chk("pwr_est_prd", 32'(pwr_est_prd),
          (eff_st == 2 || eff_st == 3) ? 32'(cfg_slow_prd) : 32'(cfg_fast_prd));
      chk("agc_locked", 32'(agc_locked), 32'(m_st == 3 || (m_st == 4 && m_ret == 3)));
      chk("agc_fail", 32'(agc_fail), 32'(m_fail));
   endtask

   // One clock: drive after negedge, step model, check after posedge
   task automatic cyc(input bit st, input bit sp, input bit fz, input bit pe, input bit fx);
      @(negedge clk);
      acq_start = st; acq_stop = sp; freeze = fz; pwr_est_end = pe; agc_fix = fx;
      model_step();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic pulse(input bit fz, input bit fx);
      cyc(0, 0, fz, 1, fx);
      cyc(0, 0, fz, 0, 0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_en"}, 32'(agc_en), 0);
      chk({tag, "_pwm"}, 32'(pwm_ena), 0);
      chk({tag, "_prd"}, 32'(pwr_est_prd), 0);
      chk({tag, "_lock"}, 32'(agc_locked), 0);
      chk({tag, "_fail"}, 32'(agc_fail), 0);
      chk({tag, "_state"}, 32'(agc_state), 0);
   endtask

   initial begin
      bit fz_lvl;
      reset = 1'b1;
      acq_start = 0; acq_stop = 0; freeze = 0; pwr_est_end = 0; agc_fix = 0;
      cfg_fast_prd = 2'd1; cfg_slow_prd = 2'd2;
      cfg_lock_cnt = 4'd3; cfg_unlock_cnt = 4'd2; cfg_timeout = 8'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      reset = 1'b0;

      // Lock, unlock, relock
      cyc(1, 0, 0, 0, 0);
      chk("start_fast", 32'(agc_state), 1);
      repeat (2) pulse(0, 1);
      chk("fast_hold_2", 32'(agc_state), 1);
      pulse(0, 1);
      chk("fast_to_slow", 32'(agc_state), 2);
      repeat (3) pulse(0, 1);
      chk("slow_to_track", 32'(agc_state), 3);
      chk("track_locked", 32'(agc_locked), 1);
      chk("track_prd", 32'(pwr_est_prd), 2);
      repeat (2) pulse(0, 0);
      chk("unlock_slow", 32'(agc_state), 2);
      chk("unlock_locked", 32'(agc_locked), 0);
      repeat (3) pulse(0, 1);
      chk("relock", 32'(agc_state), 3);
      pulse(0, 0); pulse(0, 1); pulse(0, 0);
      chk("miss_reset", 32'(agc_state), 3);
      cyc(0, 1, 0, 0, 0);
      chk("stop_state", 32'(agc_state), 0);
      chk("stop_en", 32'(agc_en), 0);
      chk("stop_lock", 32'(agc_locked), 0);

      // Timeout
      cfg_timeout = 8'd5;
      cyc(1, 0, 0, 0, 0);
      repeat (4) pulse(0, 0);
      chk("to_hold_4", 32'(agc_state), 1);
      pulse(0, 0);
      chk("to_fail_state", 32'(agc_state), 5);
      chk("to_fail_flag", 32'(agc_fail), 1);
      chk("to_fail_en", 32'(agc_en), 0);
      cyc(1, 0, 0, 0, 0);
      chk("restart_state", 32'(agc_state), 1);
      chk("restart_fail", 32'(agc_fail), 0);

      // Freeze in SLOW with fix_cnt=2, to_cnt=5
      cyc(0, 1, 0, 0, 0);
      cfg_timeout = 8'd12;
      cyc(1, 0, 0, 0, 0);
      repeat (5) pulse(0, 1);
      chk("frz_pre_slow", 32'(agc_state), 2);
      cyc(0, 0, 1, 1, 1);
      chk("frz_state", 32'(agc_state), 4);
      chk("frz_pwm", 32'(pwm_ena), 0);
      repeat (3) pulse(1, 1);
      pulse(1, 0);
      chk("frz_hold", 32'(agc_state), 4);
      chk("frz_prd", 32'(pwr_est_prd), 2);
      cyc(0, 0, 0, 0, 0);
      chk("frz_release", 32'(agc_state), 2);
      repeat (2) pulse(0, 1);
      chk("frz_fix_cleared", 32'(agc_state), 2);
      repeat (4) pulse(0, 0);
      chk("frz_to_hold", 32'(agc_state), 2);
      pulse(0, 0);
      chk("frz_to_retained", 32'(agc_state), 5);

      // Start and stop together from IDLE
      cyc(0, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      chk("start_stop_idle", 32'(agc_state), 0);

      // Zero configs
      cfg_lock_cnt = 4'd0; cfg_unlock_cnt = 4'd0; cfg_timeout = 8'd0;
      cyc(1, 0, 0, 0, 0);
      pulse(0, 1);
      chk("zero_lock_slow", 32'(agc_state), 2);
      pulse(0, 1);
      chk("zero_lock_track", 32'(agc_state), 3);
      pulse(0, 0);
      chk("zero_unlock", 32'(agc_state), 2);
      repeat (300) pulse(0, 0);
      chk("zero_to_state", 32'(agc_state), 2);
      chk("zero_to_fail", 32'(agc_fail), 0);

      // Asynchronous reset mid-operation
      @(negedge clk);
      #2 reset = 1'b1;
      #1 check_all_zero("async_rst");
      @(negedge clk);
      reset = 1'b0;
      model_reset();

      // Random traffic
      fz_lvl = 0;
      for (int i = 0; i < 4000; i++) begin
         if (m_st == 0 && ($urandom % 4) == 0) begin
            cfg_fast_prd   = 2'($urandom);
            cfg_slow_prd   = 2'($urandom);
            cfg_lock_cnt   = 4'($urandom_range(0, 4));
            cfg_unlock_cnt = 4'($urandom_range(0, 3));
            cfg_timeout    = (($urandom % 3) == 0) ? 8'd0 : 8'($urandom_range(3, 20));
         end
         if (($urandom % 25) == 0) fz_lvl = ~fz_lvl;
         cyc(($urandom % 40) == 0, ($urandom % 80) == 0, fz_lvl,
             ($urandom % 3) == 0, ($urandom % 4) != 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
